// File: rtl/cam_lookup_scheduler_if.sv
// cam_lookup_scheduler_if
//
// Bundles the request, response and CAM-control signals of cam_lookup_scheduler.
//   slave  : the scheduler's view (takes requests and CAM results, drives responses and CAM controls)
//   master : the environment's view (ingress parsers, response consumers and the CAM)
//
// Signals:
//   request_valid / request_ready            per-port request handshake (ready is a one-hot pulse)
//   request_destination_key / _source_key    packed per-port MAC keys, port p at [p*KEY_WIDTH +: KEY_WIDTH]
//   response_valid/_port/_index/_flood       one-cycle forwarding result
//   learn_drop                               pulse when a learn is skipped because the table is full
//   cam_write_enable/_match_enable/_delete_enable, cam_key, cam_index   CAM controls
//   cam_match_index/_valid, cam_no_match     registered CAM lookup result
//   entry_count, table_full                  CAM occupancy
interface cam_lookup_scheduler_if #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned KEY_WIDTH   = 48,
    parameter int unsigned TABLE_DEPTH = 32,
    parameter int unsigned INDEX_DEPTH = 8
);
    localparam int unsigned PortWidth  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned IndexWidth = (INDEX_DEPTH > 1) ? $clog2(INDEX_DEPTH) : 1;
    localparam int unsigned CountWidth = $clog2(TABLE_DEPTH + 1);

    logic [NUM_PORTS-1:0]           request_valid;
    logic [NUM_PORTS-1:0]           request_ready;
    logic [NUM_PORTS*KEY_WIDTH-1:0] request_destination_key;
    logic [NUM_PORTS*KEY_WIDTH-1:0] request_source_key;

    logic                           response_valid;
    logic [PortWidth-1:0]           response_port;
    logic [IndexWidth-1:0]          response_index;
    logic                           response_flood;
    logic                           learn_drop;

    logic                           cam_write_enable;
    logic                           cam_match_enable;
    logic                           cam_delete_enable;
    logic [KEY_WIDTH-1:0]           cam_key;
    logic [IndexWidth-1:0]          cam_index;
    logic [IndexWidth-1:0]          cam_match_index;
    logic                           cam_match_valid;
    logic                           cam_no_match;

    logic [CountWidth-1:0]          entry_count;
    logic                           table_full;

    modport slave (
        input  request_valid, request_destination_key, request_source_key,
        input  cam_match_index, cam_match_valid, cam_no_match,
        output request_ready, response_valid, response_port, response_index, response_flood,
        output learn_drop, cam_write_enable, cam_match_enable, cam_delete_enable,
        output cam_key, cam_index, entry_count, table_full
    );

    modport master (
        output request_valid, request_destination_key, request_source_key,
        output cam_match_index, cam_match_valid, cam_no_match,
        input  request_ready, response_valid, response_port, response_index, response_flood,
        input  learn_drop, cam_write_enable, cam_match_enable, cam_delete_enable,
        input  cam_key, cam_index, entry_count, table_full
    );
endinterface

// File: rtl/cam_lookup_scheduler.sv
// cam_lookup_scheduler
//
// Round-robin arbiter and sequencer for the forwarding CAM. Each granted request performs a
// destination lookup, a source lookup, optional source learning, and ends with one response.
//
// Ports:
//   clock  : single clock domain
//   reset  : asynchronous, active-high (the CAM's reset_n is driven from ~reset at the top level)
//   bus    : cam_lookup_scheduler_if.slave -- requests, responses, CAM controls and occupancy
//
// Optional feature: define CAM_LOOKUP_SCHEDULER_MOVE_EN to relearn a station seen on a new port
// (delete old entry, then write). Without it, an existing binding on another index is kept and
// the delete path is absent.
module cam_lookup_scheduler #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned KEY_WIDTH   = 48,
    parameter int unsigned TABLE_DEPTH = 32,
    parameter int unsigned INDEX_DEPTH = 8
) (
    input logic                   clock,
    input logic                   reset,
    cam_lookup_scheduler_if.slave bus
);
    localparam int unsigned PortWidth  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned IndexWidth = (INDEX_DEPTH > 1) ? $clog2(INDEX_DEPTH) : 1;
    localparam int unsigned CountWidth = $clog2(TABLE_DEPTH + 1);
    // Group (multicast) flag of a MAC address: LSB of the first octet.
    localparam int unsigned GroupBit   = 40;

    typedef enum logic [2:0] {
        StIdle,
        StDstLookup,
        StSrcLookup,
        StSrcCheck,
        StDelete,
        StWrite,
        StRespond
    } state_e;

    state_e                state_q, state_d;
    logic [PortWidth-1:0]  last_grant_q;
    logic [PortWidth-1:0]  grant_q;
    logic [KEY_WIDTH-1:0]  src_key_q;
    logic [KEY_WIDTH-1:0]  cam_key_q;
    logic [IndexWidth-1:0] cam_index_q;
    logic [IndexWidth-1:0] dst_index_q;
    logic                  dst_flood_q;
    logic                  dst_group_q;
    logic [CountWidth-1:0] entry_count_q, entry_count_d;

    logic [PortWidth-1:0]  grant_idx;
    logic                  grant_found;
    logic                  accept;
    logic [KEY_WIDTH-1:0]  grant_dst_key;
    logic [KEY_WIDTH-1:0]  grant_src_key;
    logic                  cam_hit;
    logic                  src_same_port;
    logic                  table_full;
    logic                  learn_drop;

    // Round-robin search starting one past the last grant.
    always_comb begin
        int unsigned cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = (32'(last_grant_q) + 1 + i) % NUM_PORTS;
            if (!grant_found && bus.request_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PortWidth'(cand);
            end
        end
    end

    assign accept        = (state_q == StIdle) && grant_found;
    assign grant_dst_key = bus.request_destination_key[grant_idx*KEY_WIDTH +: KEY_WIDTH];
    assign grant_src_key = bus.request_source_key[grant_idx*KEY_WIDTH +: KEY_WIDTH];

    assign cam_hit       = bus.cam_match_valid && !bus.cam_no_match;
    assign src_same_port = (bus.cam_match_index == IndexWidth'(grant_q));
    assign table_full    = (entry_count_q == CountWidth'(TABLE_DEPTH));

    // Next state and learn decision.
    always_comb begin
        state_d    = state_q;
        learn_drop = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_found) state_d = StDstLookup;
            end
            StDstLookup: state_d = StSrcLookup;
            StSrcLookup: state_d = StSrcCheck;
            StSrcCheck: begin
                if (src_key_q[GroupBit]) begin
                    state_d = StRespond;
                end else if (cam_hit) begin
                    if (src_same_port) begin
                        state_d = StRespond;
                    end else begin
`ifdef CAM_LOOKUP_SCHEDULER_MOVE_EN
                        state_d = StDelete;
`else
                        state_d = StRespond;
`endif
                    end
                end else if (!table_full) begin
                    state_d = StWrite;
                end else begin
                    learn_drop = 1'b1;
                    state_d    = StRespond;
                end
            end
`ifdef CAM_LOOKUP_SCHEDULER_MOVE_EN
            StDelete: state_d = StWrite;
`endif
            StWrite:   state_d = StRespond;
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Occupancy tracks the CAM, saturating at both ends.
    always_comb begin
        entry_count_d = entry_count_q;
        if (state_q == StWrite && entry_count_q < CountWidth'(TABLE_DEPTH)) begin
            entry_count_d = entry_count_q + 1'b1;
        end
`ifdef CAM_LOOKUP_SCHEDULER_MOVE_EN
        if (state_q == StDelete && entry_count_q != '0) begin
            entry_count_d = entry_count_q - 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            last_grant_q  <= PortWidth'(NUM_PORTS - 1);
            grant_q       <= '0;
            src_key_q     <= '0;
            cam_key_q     <= '0;
            cam_index_q   <= '0;
            dst_index_q   <= '0;
            dst_flood_q   <= 1'b0;
            dst_group_q   <= 1'b0;
            entry_count_q <= '0;
        end else begin
            state_q       <= state_d;
            entry_count_q <= entry_count_d;
            if (accept) begin
                last_grant_q <= grant_idx;
                grant_q      <= grant_idx;
                src_key_q    <= grant_src_key;
                dst_group_q  <= grant_dst_key[GroupBit];
                cam_key_q    <= grant_dst_key;
                cam_index_q  <= IndexWidth'(grant_idx);
            end
            // The key switches to the source right after the destination match cycle and
            // then stays there for the delete/write that may follow.
            if (state_q == StDstLookup) begin
                cam_key_q <= src_key_q;
            end
            // Destination result is valid one cycle after its match cycle.
            if (state_q == StSrcLookup) begin
                dst_flood_q <= dst_group_q || !cam_hit;
                dst_index_q <= bus.cam_match_index;
            end
        end
    end

    // State is already IDLE during reset; the gate keeps ready low while reset is held.
    always_comb begin
        bus.request_ready = '0;
        if (accept && !reset) begin
            bus.request_ready[grant_idx] = 1'b1;
        end
    end

    assign bus.response_valid    = (state_q == StRespond);
    assign bus.response_port     = grant_q;
    assign bus.response_index    = dst_index_q;
    assign bus.response_flood    = dst_flood_q;
    assign bus.learn_drop        = learn_drop;
    assign bus.cam_match_enable  = (state_q == StDstLookup) || (state_q == StSrcLookup);
    assign bus.cam_write_enable  = (state_q == StWrite);
`ifdef CAM_LOOKUP_SCHEDULER_MOVE_EN
    assign bus.cam_delete_enable = (state_q == StDelete);
`else
    assign bus.cam_delete_enable = 1'b0;
`endif
    assign bus.cam_key           = cam_key_q;
    assign bus.cam_index         = cam_index_q;
    assign bus.entry_count       = entry_count_q;
    assign bus.table_full        = table_full;
endmodule

// File: tb/tb_cam_lookup_scheduler.sv
module tb_cam_lookup_scheduler;
    localparam int unsigned NUM_PORTS   = 4;
    localparam int unsigned KEY_WIDTH   = 48;
    localparam int unsigned TABLE_DEPTH = 32;
    localparam int unsigned INDEX_DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cam_lookup_scheduler_if #(
        .NUM_PORTS(NUM_PORTS), .KEY_WIDTH(KEY_WIDTH),
        .TABLE_DEPTH(TABLE_DEPTH), .INDEX_DEPTH(INDEX_DEPTH)
    ) bus ();

    cam_lookup_scheduler #(
        .NUM_PORTS(NUM_PORTS), .KEY_WIDTH(KEY_WIDTH),
        .TABLE_DEPTH(TABLE_DEPTH), .INDEX_DEPTH(INDEX_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- CAM behavioural model (environment side) ----------------
    logic        cam_used [TABLE_DEPTH];
    logic [47:0] cam_keys [TABLE_DEPTH];
    logic [2:0]  cam_idx  [TABLE_DEPTH];
    logic        cam_hit;
    logic [2:0]  cam_hit_idx;
    logic        cam_free_ok;
    int          cam_free_slot;

    always_comb begin
        cam_hit = 1'b0; cam_hit_idx = '0; cam_free_ok = 1'b0; cam_free_slot = 0;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            if (!cam_hit && cam_used[i] && cam_keys[i] == bus.cam_key) begin
                cam_hit = 1'b1; cam_hit_idx = cam_idx[i];
            end
            if (!cam_free_ok && !cam_used[i]) begin
                cam_free_ok = 1'b1; cam_free_slot = i;
            end
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                cam_used[i] <= 1'b0; cam_keys[i] <= '0; cam_idx[i] <= '0;
            end
            bus.cam_match_valid <= 1'b0;
            bus.cam_no_match    <= 1'b0;
            bus.cam_match_index <= '0;
        end else begin
            if (bus.cam_match_enable) begin
                bus.cam_match_valid <= cam_hit;
                bus.cam_no_match    <= !cam_hit;
                bus.cam_match_index <= cam_hit_idx;
            end
            if (bus.cam_write_enable && cam_free_ok) begin
                cam_used[cam_free_slot] <= 1'b1;
                cam_keys[cam_free_slot] <= bus.cam_key;
                cam_idx[cam_free_slot]  <= bus.cam_index;
            end
            if (bus.cam_delete_enable) begin
                for (int i = 0; i < TABLE_DEPTH; i++) begin
                    if (cam_used[i] && cam_keys[i] == bus.cam_key) cam_used[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- Event monitors ----------------
    int         wr_cnt = 0, del_cnt = 0, drop_cnt = 0, onehot_err = 0, resp_cnt = 0;
    logic [2:0] last_wr_index = '0;
    always @(negedge clock) begin
        if (bus.cam_write_enable) begin
            wr_cnt <= wr_cnt + 1; last_wr_index <= bus.cam_index;
        end
        if (bus.cam_delete_enable) del_cnt <= del_cnt + 1;
        if (bus.learn_drop) drop_cnt <= drop_cnt + 1;
        if (bus.response_valid) resp_cnt <= resp_cnt + 1;
        if (32'(bus.cam_write_enable) + 32'(bus.cam_match_enable) + 32'(bus.cam_delete_enable) > 1)
            onehot_err <= onehot_err + 1;
    end

    // ---------------- Reference model ----------------
    int unsigned   mdl [logic [47:0]];   // learned station -> port
    logic [47:0]   known_q [$];
    int            last_grant_m = NUM_PORTS - 1;
    int            passed = 0, total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [47:0] rand_unicast();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        r[40] = 1'b0;
        return r[47:0];
    endfunction

    function automatic logic [47:0] new_source();
        logic [47:0] k;
        k = rand_unicast();
        while (mdl.exists(k)) k = rand_unicast();
        return k;
    endfunction

    function automatic logic [47:0] pick_known();
        if (known_q.size() == 0) return rand_unicast();
        return known_q[$urandom_range(known_q.size() - 1)];
    endfunction

    task automatic send(input int p, input logic [47:0] dst, input logic [47:0] src);
        int  exp_lat, lat, w0, d0, r0;
        bit  exp_flood, exp_write, exp_delete, exp_drop, got;
        logic [2:0] exp_idx;
        exp_flood  = dst[40] || !mdl.exists(dst);
        exp_idx    = exp_flood ? 3'd0 : 3'(mdl[dst]);
        exp_write  = 0; exp_delete = 0; exp_drop = 0; exp_lat = 4;
        if (!src[40]) begin
            if (mdl.exists(src)) begin
                if (mdl[src] != p) begin
`ifdef CAM_LOOKUP_SCHEDULER_MOVE_EN
                    exp_delete = 1; exp_write = 1; exp_lat = 6;
`endif
                end
            end else if (mdl.num() < TABLE_DEPTH) begin
                exp_write = 1; exp_lat = 5;
            end else begin
                exp_drop = 1;
            end
        end
        w0 = wr_cnt; d0 = del_cnt; r0 = drop_cnt;

        @(negedge clock);
        bus.request_destination_key[p*KEY_WIDTH +: KEY_WIDTH] = dst;
        bus.request_source_key[p*KEY_WIDTH +: KEY_WIDTH]      = src;
        bus.request_valid[p] = 1'b1;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            if (bus.request_ready[p]) got = 1;
            else @(negedge clock);
        end
        check("grant_onehot", 64'(bus.request_ready), 64'(1 << p));
        @(posedge clock);
        #1;
        bus.request_valid[p] = 1'b0;
        lat = 1; got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (bus.response_valid) got = 1;
            else begin
                @(posedge clock); #1; lat++;
            end
        end
        check("latency", got ? 64'(lat) : 64'(0), 64'(exp_lat));
        check("resp_port", 64'(bus.response_port), 64'(p));
        check("resp_flood", 64'(bus.response_flood), 64'(exp_flood));
        if (!exp_flood) check("resp_index", 64'(bus.response_index), 64'(exp_idx));

        if (exp_write) begin
            if (!mdl.exists(src)) known_q.push_back(src);
            mdl[src] = p;
        end
        last_grant_m = p;
        check("entry_count", 64'(bus.entry_count), 64'(mdl.num()));
        check("table_full", 64'(bus.table_full), 64'(mdl.num() == TABLE_DEPTH));
        check("writes", 64'(wr_cnt - w0), 64'(exp_write));
        check("deletes", 64'(del_cnt - d0), 64'(exp_delete));
        check("learn_drop", 64'(drop_cnt - r0), 64'(exp_drop));
        if (exp_write) check("write_index", 64'(last_wr_index), 64'(p));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int exp_g, r0, p;
        bit got;
        logic [47:0] dst, src;
        bus.request_valid = '0;
        bus.request_destination_key = '0;
        bus.request_source_key = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ready", 64'(bus.request_ready), 0);
        check("rst_resp_valid", 64'(bus.response_valid), 0);
        check("rst_resp_port", 64'(bus.response_port), 0);
        check("rst_resp_flood", 64'(bus.response_flood), 0);
        check("rst_cam_ctrl", 64'({bus.cam_write_enable, bus.cam_match_enable, bus.cam_delete_enable}), 0);
        check("rst_cam_key", 64'(bus.cam_key), 0);
        check("rst_entry_count", 64'(bus.entry_count), 0);
        check("rst_table_full", 64'(bus.table_full), 0);
        check("rst_learn_drop", 64'(bus.learn_drop), 0);
        reset = 1'b0;

        // Round robin with every port requesting; group keys keep the table untouched.
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus.request_destination_key[i*KEY_WIDTH +: KEY_WIDTH] = 48'hFFFF_FFFF_FFFF;
            bus.request_source_key[i*KEY_WIDTH +: KEY_WIDTH]      = 48'h0100_5E00_0001 + 48'(i);
        end
        @(negedge clock);
        bus.request_valid = '1;
        for (int g = 0; g < 5; g++) begin
            exp_g = (last_grant_m + 1) % NUM_PORTS;
            got = 0;
            for (int n = 0; n < 20 && !got; n++) begin
                #1;
                if (|bus.request_ready) got = 1;
                else @(negedge clock);
            end
            check("rr_grant", 64'(bus.request_ready), 64'(1 << exp_g));
            last_grant_m = exp_g;
            @(negedge clock);
        end
        bus.request_valid = '0;
        repeat (8) @(negedge clock);
        check("rr_entry_count", 64'(bus.entry_count), 0);

        // Directed cases
        send(1, 48'h0000_0000_00AA, 48'h0000_0000_0011);
        send(2, 48'h0000_0000_0011, 48'h0000_0000_0022);
        send(3, 48'h0000_0000_0033, 48'h0000_0000_0011);   // station move
        send(0, 48'h0000_0000_0011, 48'h0000_0000_0044);
        send(0, 48'h0000_0000_0044, 48'h0000_0000_0044);   // dst==src, already known
        send(1, 48'h0000_0000_0055, 48'h0000_0000_0055);   // dst==src, unknown -> floods
        send(2, 48'hFFFF_FFFF_FFFF, 48'h0100_5E00_0001);   // broadcast dst, group src
        send(3, 48'h0100_5E00_0001, pick_known());

        // Fill the table, then overflow
        while (mdl.num() < TABLE_DEPTH) begin
            p   = $urandom_range(NUM_PORTS - 1);
            dst = ($urandom_range(1) == 1) ? pick_known() : rand_unicast();
            send(p, dst, new_source());
        end
        send(0, pick_known(), new_source());

        // Random traffic on a full table: moves, relearns, groups and drops
        for (int i = 0; i < 40; i++) begin
            p   = $urandom_range(NUM_PORTS - 1);
            dst = ($urandom_range(1) == 1) ? pick_known() : rand_unicast();
            case ($urandom_range(4))
                0:       src = 48'h0100_5E00_0000 | 48'($urandom_range(255));
                1, 2:    src = pick_known();
                default: src = new_source();
            endcase
            send(p, dst, src);
        end

        // Reset in the middle of a learning sequence
        @(negedge clock);
        bus.request_destination_key[0 +: KEY_WIDTH] = rand_unicast();
        bus.request_source_key[0 +: KEY_WIDTH]      = new_source();
        bus.request_valid[0] = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (bus.request_ready[0]) got = 1;
            else @(negedge clock);
        end
        check("abort_grant", 64'(bus.request_ready), 64'(1));
        @(negedge clock);
        bus.request_valid[0] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        r0 = resp_cnt;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        mdl.delete();
        known_q.delete();
        last_grant_m = NUM_PORTS - 1;
        repeat (8) @(negedge clock);
        check("abort_no_response", 64'(resp_cnt - r0), 0);
        check("abort_entry_count", 64'(bus.entry_count), 0);
        send(2, 48'h0000_0000_0011, 48'h0000_0000_0066);
        send(1, 48'h0000_0000_0066, 48'h0000_0000_0011);

        check("cam_ctrl_exclusive", 64'(onehot_err), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
